// File: rtl/l2_switch_pkg.sv
// Shared frame layout {dst,src,payload}, node IDs and arbiter FSM state encodings
// for the L2 switch port arbiter (optional stats build: L2_ARB_STATS_EN).
package l2_switch_pkg;

  localparam int ID_W      = 4;
  localparam int PAYLOAD_W = 4;
  localparam int FRAME_W   = 2*ID_W + PAYLOAD_W;
  localparam int PL_LSB    = 0;
  localparam int SRC_LSB   = PL_LSB + PAYLOAD_W;
  localparam int DST_LSB   = SRC_LSB + ID_W;

  localparam logic [ID_W-1:0] NODE_A = 4'hA;
  localparam logic [ID_W-1:0] NODE_B = 4'hB;
  localparam logic [ID_W-1:0] NODE_C = 4'hC;
  localparam logic [ID_W-1:0] NODE_D = 4'hD;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT   = 3'd1;
  localparam logic [2:0] ST_XFER    = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // A frame addressed to its own sender never enters the fabric.
  function automatic logic is_loopback(input logic [FRAME_W-1:0] f);
    return f[DST_LSB +: ID_W] == f[SRC_LSB +: ID_W];
  endfunction

  function automatic logic [FRAME_W-1:0] make_frame(input logic [ID_W-1:0] dst,
                                                    input logic [ID_W-1:0] src,
                                                    input logic [PAYLOAD_W-1:0] pl);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[DST_LSB +: ID_W]     = dst;
    f[SRC_LSB +: ID_W]     = src;
    f[PL_LSB +: PAYLOAD_W] = pl;
    return f;
  endfunction

endpackage

// File: rtl/l2_rr_pick.sv
// Combinational rotate-priority pick: first set request bit at or after the
// round-robin pointer, wrapping modulo N_PORTS.
module l2_rr_pick
  import l2_switch_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_idx [N_PORTS];

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_idx
      assign w_idx[gi] = IDX_W'((int'(i_rr_ptr) + gi) % N_PORTS);
    end
  endgenerate

  // Scan from lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (i_req[w_idx[k]]) begin
        o_winner = w_idx[k];
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_switch_port_arbiter.sv
// Round-robin owner of the shared switch fabric: latch one port's frame, hand it
// over with valid/ready, hold the fabric, then ack. Define L2_ARB_STATS_EN for grant counters.
module l2_switch_port_arbiter
  import l2_switch_pkg::*;
#(
  parameter int N_PORTS      = 4,
  parameter int FRAME_CYCLES = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                       FPGA_CLK,
  input  logic                       FPGA_RST_BTN,
  input  logic [N_PORTS-1:0]         req,
  input  logic [N_PORTS*FRAME_W-1:0] frame_in,
  input  logic                       fab_ready,
  output logic [N_PORTS-1:0]         grant,
  output logic                       fab_valid,
  output logic [FRAME_W-1:0]         fab_frame,
  output logic [N_PORTS-1:0]         req_ack,
  output logic [N_PORTS-1:0]         drop,
  output logic                       busy,
  output logic [N_PORTS*8-1:0]       stat_cnt
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int HC_W  = $clog2(FRAME_CYCLES + 1);

  logic [2:0]         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_winner;
  logic [FRAME_W-1:0] r_frame;
  logic               r_dropped;
  logic [TO_W-1:0]    r_to_cnt;
  logic [HC_W-1:0]    r_hold_cnt;
  logic [N_PORTS-1:0] r_grant;
  logic [N_PORTS-1:0] r_req_ack;
  logic [N_PORTS-1:0] r_drop;
  logic               r_fab_valid;
  logic               r_busy;

  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_rr_next;

  l2_rr_pick #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_rr_next = (r_winner == IDX_W'(N_PORTS - 1)) ? '0 : r_winner + IDX_W'(1);

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_winner    <= '0;
      r_frame     <= '0;
      r_dropped   <= 1'b0;
      r_to_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_grant     <= '0;
      r_req_ack   <= '0;
      r_drop      <= '0;
      r_fab_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_req_ack <= '0;
      r_drop    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_winner <= w_pick_idx;
            r_frame  <= frame_in[w_pick_idx*FRAME_W +: FRAME_W];
            r_grant  <= N_PORTS'(1) << w_pick_idx;
            r_busy   <= 1'b1;
            r_state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_to_cnt <= '0;
          if (is_loopback(r_frame)) begin
            r_dropped <= 1'b1;
            r_req_ack <= r_grant;
            r_drop    <= r_grant;
            r_state   <= ST_RELEASE;
          end else begin
            r_dropped   <= 1'b0;
            r_fab_valid <= 1'b1;
            r_state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          r_hold_cnt <= '0;
          // A ready arriving in the last allowed cycle still wins over the timeout.
          if (fab_ready) begin
            r_fab_valid <= 1'b0;
            r_state     <= ST_HOLD;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            r_fab_valid <= 1'b0;
            r_dropped   <= 1'b1;
            r_req_ack   <= r_grant;
            r_drop      <= r_grant;
            r_state     <= ST_RELEASE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HC_W'(FRAME_CYCLES - 1)) begin
            r_req_ack <= r_grant;
            r_state   <= ST_RELEASE;
          end else begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end
        end
        ST_RELEASE: begin
          r_rr_ptr <= w_rr_next;
          r_grant  <= '0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_grant     <= '0;
          r_fab_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign fab_valid = r_fab_valid;
  assign fab_frame = r_frame;
  assign req_ack   = r_req_ack;
  assign drop      = r_drop;
  assign busy      = r_busy;

`ifdef L2_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_stat
      logic [7:0] r_stat;
      always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
        if (!FPGA_RST_BTN) begin
          r_stat <= '0;
        end else if (r_state == ST_RELEASE && !r_dropped &&
                     r_winner == IDX_W'(gi) && r_stat != 8'hFF) begin
          r_stat <= r_stat + 8'd1;
        end
      end
      assign stat_cnt[gi*8 +: 8] = r_stat;
    end
  endgenerate
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_l2_switch_port_arbiter.sv
// Bench for l2_switch_port_arbiter: timestamp-based frame model checked every cycle,
// plus directed transactions with literal timing/grant expectations (L2_ARB_STATS_EN aware).
module tb_l2_switch_port_arbiter;
  import l2_switch_pkg::*;

  localparam int NP = 4;
  localparam int FC = 4;
  localparam int TO = 16;
`ifdef L2_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     req;
  logic [NP*12-1:0]  frame_in;
  logic              fab_ready;
  logic [NP-1:0]     grant;
  logic              fab_valid;
  logic [11:0]       fab_frame;
  logic [NP-1:0]     req_ack;
  logic [NP-1:0]     drop;
  logic              busy;
  logic [NP*8-1:0]   stat_cnt;

  l2_switch_port_arbiter #(
    .N_PORTS      (NP),
    .FRAME_CYCLES (FC),
    .TIMEOUT      (TO)
  ) dut (
    .FPGA_CLK     (clk),
    .FPGA_RST_BTN (rst_n),
    .req          (req),
    .frame_in     (frame_in),
    .fab_ready    (fab_ready),
    .grant        (grant),
    .fab_valid    (fab_valid),
    .fab_frame    (fab_frame),
    .req_ack      (req_ack),
    .drop         (drop),
    .busy         (busy),
    .stat_cnt     (stat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Model: tracks the owner and the absolute cycles at which its frame starts,
  // becomes valid and is acknowledged; expectations follow from those timestamps.
  int          cyc;
  logic        m_busy;
  int          m_owner, m_rr, m_grant_c, m_vstart, m_ack_c;
  logic        m_drop_f;
  logic [11:0] m_frame;
  logic [7:0]  m_stat [NP];
  logic [NP-1:0] exp_grant, exp_ack, exp_drop;
  logic        exp_valid, exp_busy;
  int          m_idx;
  logic        m_found;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_busy = 1'b0; m_owner = 0; m_rr = 0;
      m_grant_c = -1; m_vstart = -1; m_ack_c = -1; m_drop_f = 1'b0; m_frame = '0;
      for (int i = 0; i < NP; i++) m_stat[i] = '0;
      exp_grant = '0; exp_ack = '0; exp_drop = '0; exp_valid = 1'b0; exp_busy = 1'b0;
    end else begin
      if (!m_busy) begin
        m_found = 1'b0;
        for (int k = 0; k < NP; k++) begin
          m_idx = (m_rr + k) % NP;
          if (!m_found && req[m_idx]) begin
            m_found = 1'b1;
            m_owner = m_idx;
          end
        end
        if (m_found) begin
          m_busy = 1'b1;
          m_frame = frame_in[m_owner*12 +: 12];
          m_grant_c = cyc + 1; m_vstart = -1; m_ack_c = -1; m_drop_f = 1'b0;
        end
      end else if (cyc == m_ack_c) begin
        m_busy = 1'b0;
        m_rr = (m_owner + 1) % NP;
        if (STATS && !m_drop_f && m_stat[m_owner] != 8'hFF) m_stat[m_owner] = m_stat[m_owner] + 8'd1;
      end else if (cyc == m_grant_c) begin
        if (m_frame[11:8] == m_frame[7:4]) begin
          m_ack_c = cyc + 1; m_drop_f = 1'b1;
        end else begin
          m_vstart = cyc + 1;
        end
      end else if (exp_valid) begin
        if (fab_ready) begin
          m_ack_c = cyc + 1 + FC;
        end else if (cyc - m_vstart + 1 == TO) begin
          m_ack_c = cyc + 1; m_drop_f = 1'b1;
        end
      end
      cyc++;
      exp_busy  = m_busy;
      exp_grant = m_busy ? (NP'(1) << m_owner) : '0;
      exp_valid = m_busy && m_vstart >= 0 && m_ack_c < 0;
      exp_ack   = (m_busy && cyc == m_ack_c) ? exp_grant : '0;
      exp_drop  = m_drop_f ? exp_ack : '0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("grant", 64'(grant), 64'(exp_grant));
      check("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
      check("fab_valid", 64'(fab_valid), 64'(exp_valid));
      if (exp_valid) check("fab_frame", 64'(fab_frame), 64'(m_frame));
      check("req_ack", 64'(req_ack), 64'(exp_ack));
      check("drop", 64'(drop), 64'(exp_drop));
      check("busy", 64'(busy), 64'(exp_busy));
      check("stat_cnt", 64'(stat_cnt), 64'({m_stat[3], m_stat[2], m_stat[1], m_stat[0]}));
      if (req_ack != 0) $display("txn cyc=%0d ack=%b drop=%b", cyc, req_ack, drop);
    end
  end

  // Requester behaviour: drop req the cycle after its ack; re-raise only if rearm.
  logic [NP-1:0] want;
  logic [NP-1:0] ack_prev;
  logic          rearm;

  task automatic tick();
    @(negedge clk);
    ack_prev = req_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (ack_prev[i]) begin
        req[i] = 1'b0;
        if (!rearm) want[i] = 1'b0;
      end else begin
        req[i] = want[i];
      end
    end
  endtask

  task automatic request(input logic [NP-1:0] mask);
    want = want | mask;
    req  = req | mask;
  endtask

  task automatic set_frame(input int p, input logic [11:0] f);
    frame_in[p*12 +: 12] = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; want = '0; fab_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ready_at: 0 keeps fab_ready as is, >0 raises it on that valid cycle, <0 holds it low.
  task automatic run_txn(input int ready_at, output int t_g, output int t_v, output int n_v,
                         output int t_a, output logic [NP-1:0] g, output logic [NP-1:0] a,
                         output logic [NP-1:0] d, output logic [11:0] fr);
    t_g = -1; t_v = -1; n_v = 0; t_a = -1; g = '0; a = '0; d = '0; fr = '0;
    if (ready_at != 0) fab_ready = 1'b0;
    for (int t = 1; t <= 60 && t_a < 0; t++) begin
      tick();
      if (t_g < 0 && grant != 0) begin t_g = t; g = grant; end
      if (fab_valid) begin
        n_v++;
        if (t_v < 0) begin t_v = t; fr = fab_frame; end
        if (ready_at > 0 && n_v == ready_at) fab_ready = 1'b1;
      end
      if (req_ack != 0) begin t_a = t; a = req_ack; d = drop; end
    end
    if (t_a < 0) begin
      checks++; errors++;
      $display("FAIL txn_budget no req_ack within 60 cycles");
    end
  endtask

  int t_g, t_v, n_v, t_a, n_g;
  logic [NP-1:0] g, a, d, prev_g;
  logic [11:0] fr;
  logic [NP-1:0] seq [5];
  logic [NP-1:0] exp_seq [5];

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) seq[i] = '0;
    rst_n = 1'b0; req = '0; want = '0; rearm = 1'b0; fab_ready = 1'b0; frame_in = '0;
    set_frame(0, make_frame(NODE_C, NODE_A, 4'h5));
    set_frame(1, make_frame(NODE_D, NODE_B, 4'h1));
    set_frame(2, make_frame(NODE_A, NODE_C, 4'h3));
    set_frame(3, make_frame(NODE_B, NODE_D, 4'h9));
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_fab_valid", 64'(fab_valid), 64'd0);
    check("rst_fab_frame", 64'(fab_frame), 64'd0);
    check("rst_req_ack", 64'(req_ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stat", 64'(stat_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // All four ports requesting continuously: strict rotation from port 0.
    fab_ready = 1'b1; rearm = 1'b1; request(4'b1111);
    prev_g = '0; n_g = 0;
    for (int t = 0; t < 120 && n_g < 5; t++) begin
      tick();
      if (grant != 0 && prev_g == 0) begin seq[n_g] = grant; n_g++; end
      prev_g = grant;
    end
    rearm = 1'b0; want = '0;
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
    for (int t = 0; t < 40 && busy; t++) tick();
    check("rr_drain_busy", 64'(busy), 64'd0);
    tick();

    // Single frame from port 0, always-ready fabric.
    request(4'b0001);
    run_txn(0, t_g, t_v, n_v, t_a, g, a, d, fr);
    check("p0_grant_cycle", 64'(t_g), 64'd1);
    check("p0_grant", 64'(g), 64'b0001);
    check("p0_valid_cycle", 64'(t_v), 64'd2);
    check("p0_frame", 64'(fr), 64'hCA5);
    check("p0_ack_cycle", 64'(t_a), 64'd7);
    check("p0_ack", 64'(a), 64'b0001);
    check("p0_drop", 64'(d), 64'd0);
    tick();
    check("p0_idle_busy", 64'(busy), 64'd0);

    // Port 2 against a fabric that never accepts: timeout drop.
    request(4'b0100);
    run_txn(-1, t_g, t_v, n_v, t_a, g, a, d, fr);
    check("to_valid_cycles", 64'(n_v), 64'd16);
    check("to_valid_start", 64'(t_v), 64'd2);
    check("to_ack_cycle", 64'(t_a), 64'd18);
    check("to_ack", 64'(a), 64'b0100);
    check("to_drop", 64'(d), 64'b0100);
    tick();
    check("to_busy_fall", 64'(busy), 64'd0);

    // Port 1 loopback frame: dropped without touching the fabric.
    fab_ready = 1'b1;
    set_frame(1, make_frame(NODE_B, NODE_B, 4'h7));
    request(4'b0010);
    run_txn(0, t_g, t_v, n_v, t_a, g, a, d, fr);
    check("lb_valid_cycles", 64'(n_v), 64'd0);
    check("lb_ack_cycle", 64'(t_a), 64'd2);
    check("lb_ack", 64'(a), 64'b0010);
    check("lb_drop", 64'(d), 64'b0010);
    tick();
    // Pointer now at 2: port 2 beats port 0, then port 0 follows.
    request(4'b0101);
    run_txn(0, t_g, t_v, n_v, t_a, g, a, d, fr);
    check("ptr2_winner", 64'(g), 64'b0100);
    tick();
    run_txn(0, t_g, t_v, n_v, t_a, g, a, d, fr);
    check("ptr3_winner", 64'(g), 64'b0001);
    check("ptr3_grant_cycle", 64'(t_g), 64'd1);
    tick();

    // Ready arrives on the last valid cycle before timeout: frame is sent.
    request(4'b0001);
    run_txn(16, t_g, t_v, n_v, t_a, g, a, d, fr);
    check("late_valid_cycles", 64'(n_v), 64'd16);
    check("late_ack_cycle", 64'(t_a), 64'd22);
    check("late_ack", 64'(a), 64'b0001);
    check("late_drop", 64'(d), 64'd0);
    tick();

    // Asynchronous reset in the middle of a transfer.
    fab_ready = 1'b0;
    request(4'b1000);
    tick(); tick(); tick();
    check("xfer_before_rst_valid", 64'(fab_valid), 64'd1);
    check("xfer_before_rst_grant", 64'(grant), 64'b1000);
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", 64'(grant), 64'd0);
    check("arst_fab_valid", 64'(fab_valid), 64'd0);
    check("arst_fab_frame", 64'(fab_frame), 64'd0);
    check("arst_req_ack", 64'(req_ack), 64'd0);
    check("arst_drop", 64'(drop), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_stat", 64'(stat_cnt), 64'd0);
    req = '0; want = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fab_ready = 1'b1;
    request(4'b1000);
    run_txn(0, t_g, t_v, n_v, t_a, g, a, d, fr);
    check("post_rst_grant", 64'(g), 64'b1000);
    check("post_rst_grant_cycle", 64'(t_g), 64'd1);
    tick();

    // Statistics: three delivered frames and one loopback drop from port 3.
    do_reset();
    fab_ready = 1'b1;
    tick();
    set_frame(3, make_frame(NODE_B, NODE_D, 4'h9));
    for (int n = 0; n < 3; n++) begin
      request(4'b1000);
      run_txn(0, t_g, t_v, n_v, t_a, g, a, d, fr);
      check($sformatf("st_sent%0d_drop", n), 64'(d), 64'd0);
      tick();
    end
    set_frame(3, make_frame(NODE_D, NODE_D, 4'h2));
    request(4'b1000);
    run_txn(0, t_g, t_v, n_v, t_a, g, a, d, fr);
    check("st_lb_drop", 64'(d), 64'b1000);
    tick();
    check("st_port3", 64'(stat_cnt[31:24]), STATS ? 64'd3 : 64'd0);
    check("st_others", 64'(stat_cnt[23:0]), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
